// File: rtl/top_bounce.sv
`default_nettype none
// ============================================================================
//  Module   : top_bounce
//  Purpose  : Bouncing-square demo renderer. A Q_SIZE x Q_SIZE square moves
//             Q_SPEED pixels per axis once per frame, reverses at the screen
//             edges and changes colour on every frame that contains a bounce.
//             Pixel colour is produced by a 2-stage pipeline that runs in
//             step with the incoming display coordinates.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_pix     in   1      pixel clock (only clock)
//    sim_rst     in   1      asynchronous active-high reset
//    sx, sy      in   CORDW  current screen position
//    de          in   1      data enable, low in blanking
//    pause       in   1      freezes motion while high
//    sdl_sx/sy   out  CORDW  sx/sy delayed 2 cycles
//    sdl_de      out  1      de delayed 2 cycles
//    sdl_r/g/b   out  8      pixel colour, 2-cycle latency
//    qx, qy      out  CORDW  square top-left
//    bounce_cnt  out  8      count of frames containing a bounce (wraps)
// ============================================================================
module top_bounce #(
    parameter int CORDW   = 10,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int Q_SIZE  = 200,
    parameter int Q_SPEED = 2,
    parameter int INIT_X  = 220,
    parameter int INIT_Y  = 140
) (
    input  logic             clk_pix,
    input  logic             sim_rst,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic             pause,
    output logic [CORDW-1:0] sdl_sx,
    output logic [CORDW-1:0] sdl_sy,
    output logic             sdl_de,
    output logic [7:0]       sdl_r,
    output logic [7:0]       sdl_g,
    output logic [7:0]       sdl_b,
    output logic [CORDW-1:0] qx,
    output logic [CORDW-1:0] qy,
    output logic [7:0]       bounce_cnt
);

    // Extended width so edge sums cannot overflow the coordinate range.
    localparam int EW = CORDW + 1;

    localparam logic [EW-1:0]    c_H_RES_E   = EW'(H_RES);
    localparam logic [EW-1:0]    c_V_RES_E   = EW'(V_RES);
    localparam logic [EW-1:0]    c_SIZE_E    = EW'(Q_SIZE);
    localparam logic [EW-1:0]    c_SPEED_E   = EW'(Q_SPEED);
    localparam logic [CORDW-1:0] c_SPEED     = CORDW'(Q_SPEED);
    localparam logic [CORDW-1:0] c_INIT_X    = CORDW'(INIT_X);
    localparam logic [CORDW-1:0] c_INIT_Y    = CORDW'(INIT_Y);
    localparam logic [CORDW-1:0] c_TICK_SY   = CORDW'(V_RES);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    if (Q_SPEED < 1) begin : g_bad_speed
        $error("top_bounce: Q_SPEED must be >= 1");
    end
    if (Q_SIZE + 2 * Q_SPEED >= H_RES || Q_SIZE + 2 * Q_SPEED >= V_RES) begin : g_bad_size
        $error("top_bounce: Q_SIZE + 2*Q_SPEED must be below H_RES and V_RES");
    end
    if (INIT_X + Q_SIZE >= H_RES || INIT_Y + Q_SIZE >= V_RES) begin : g_bad_init
        $error("top_bounce: initial square position must lie on screen");
    end

    // ------------------------------------------------------------------------
    // Motion state
    // ------------------------------------------------------------------------
    logic [CORDW-1:0] qx_q, qx_d;
    logic [CORDW-1:0] qy_q, qy_d;
    logic             dx_q, dx_d;
    logic             dy_q, dy_d;
    logic [1:0]       col_q, col_d;
    logic [7:0]       bcnt_q, bcnt_d;

    logic             tick;
    logic [EW-1:0]    qx_e, qy_e;
    logic             rev_x, rev_y;

    // The tick lands in vertical blanking, so a visible frame never sees
    // two different square positions.
    assign tick = (sx == '0) && (sy == c_TICK_SY) && !pause;
    assign qx_e = {1'b0, qx_q};
    assign qy_e = {1'b0, qy_q};

    always_comb begin
        qx_d   = qx_q;
        qy_d   = qy_q;
        dx_d   = dx_q;
        dy_d   = dy_q;
        col_d  = col_q;
        bcnt_d = bcnt_q;
        rev_x  = 1'b0;
        rev_y  = 1'b0;
        if (tick) begin
            if (dx_q) begin
                if (qx_e + c_SIZE_E + c_SPEED_E >= c_H_RES_E) begin
                    dx_d  = 1'b0;
                    qx_d  = qx_q - c_SPEED;
                    rev_x = 1'b1;
                end else begin
                    qx_d = qx_q + c_SPEED;
                end
            end else begin
                if (qx_e < c_SPEED_E) begin
                    dx_d  = 1'b1;
                    qx_d  = qx_q + c_SPEED;
                    rev_x = 1'b1;
                end else begin
                    qx_d = qx_q - c_SPEED;
                end
            end

            if (dy_q) begin
                if (qy_e + c_SIZE_E + c_SPEED_E >= c_V_RES_E) begin
                    dy_d  = 1'b0;
                    qy_d  = qy_q - c_SPEED;
                    rev_y = 1'b1;
                end else begin
                    qy_d = qy_q + c_SPEED;
                end
            end else begin
                if (qy_e < c_SPEED_E) begin
                    dy_d  = 1'b1;
                    qy_d  = qy_q + c_SPEED;
                    rev_y = 1'b1;
                end else begin
                    qy_d = qy_q - c_SPEED;
                end
            end

            // A corner reverses both axes but still counts as one bounce.
            if (rev_x || rev_y) begin
                bcnt_d = bcnt_q + 8'd1;
                col_d  = col_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_pix or posedge sim_rst) begin
        if (sim_rst) begin
            qx_q   <= c_INIT_X;
            qy_q   <= c_INIT_Y;
            dx_q   <= 1'b1;
            dy_q   <= 1'b1;
            col_q  <= 2'd0;
            bcnt_q <= 8'd0;
        end else begin
            qx_q   <= qx_d;
            qy_q   <= qy_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            col_q  <= col_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign qx         = qx_q;
    assign qy         = qy_q;
    assign bounce_cnt = bcnt_q;

    // ------------------------------------------------------------------------
    // Stage 1: register coordinates and the inside-square test
    // ------------------------------------------------------------------------
    logic [CORDW-1:0] s1_sx_q, s1_sy_q;
    logic             s1_de_q, s1_sq_q;
    logic             square;
    logic [EW-1:0]    sx_e, sy_e;

    assign sx_e   = {1'b0, sx};
    assign sy_e   = {1'b0, sy};
    assign square = (sx_e >= qx_e) && (sx_e < qx_e + c_SIZE_E) &&
                    (sy_e >= qy_e) && (sy_e < qy_e + c_SIZE_E);

    always_ff @(posedge clk_pix or posedge sim_rst) begin
        if (sim_rst) begin
            s1_sx_q <= '0;
            s1_sy_q <= '0;
            s1_de_q <= 1'b0;
            s1_sq_q <= 1'b0;
        end else begin
            s1_sx_q <= sx;
            s1_sy_q <= sy;
            s1_de_q <= de;
            s1_sq_q <= square;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: colour lookup and output registers
    // ------------------------------------------------------------------------
    logic [3:0] r4, g4, b4;

    always_comb begin
        r4 = 4'h1;
        g4 = 4'h3;
        b4 = 4'h7;
        if (!s1_de_q) begin
            r4 = 4'h0;
            g4 = 4'h0;
            b4 = 4'h0;
        end else if (s1_sq_q) begin
            case (col_q)
                2'd0:    begin r4 = 4'hF; g4 = 4'hF; b4 = 4'hF; end
                2'd1:    begin r4 = 4'hF; g4 = 4'h4; b4 = 4'h4; end
                2'd2:    begin r4 = 4'h4; g4 = 4'hF; b4 = 4'h4; end
                default: begin r4 = 4'hF; g4 = 4'hF; b4 = 4'h4; end
            endcase
        end
    end

    always_ff @(posedge clk_pix or posedge sim_rst) begin
        if (sim_rst) begin
            sdl_sx <= '0;
            sdl_sy <= '0;
            sdl_de <= 1'b0;
            sdl_r  <= 8'h00;
            sdl_g  <= 8'h00;
            sdl_b  <= 8'h00;
        end else begin
            sdl_sx <= s1_sx_q;
            sdl_sy <= s1_sy_q;
            sdl_de <= s1_de_q;
            sdl_r  <= {2{r4}};
            sdl_g  <= {2{g4}};
            sdl_b  <= {2{b4}};
        end
    end

endmodule
`default_nettype wire
